flag_branch_unit: RTL and testbench
===================================

Name: flag_branch_unit

Overview:
- Consumer side of the ALU flag interface.
- Latches the ALU's Z/V/N set signals into the architectural flag register, masked per opcode class.
- Evaluates 3-bit branch condition codes against those flags and returns a registered taken/not-taken result to fetch.
- Handles the EX-writes/ID-reads flag hazard by forwarding or by stalling, and keeps saturating branch statistics counters.

Parameters:
- FWD_EN, 1: 1 = branch evaluation uses the flags being written this cycle (bypass); 0 = raise hazard_stall instead.
- CNT_W, 16: width of the statistics counters.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- ex_valid  input  1  EX-stage instruction valid.
- ex_opcode  input  4  EX-stage opcode (same encoding as the ALU Opcode).
- Z_set  input  1  zero flag from the ALU.
- V_set  input  1  overflow flag from the ALU.
- N_set  input  1  negative flag from the ALU.
- stall  input  1  pipeline stall; freezes all state.
- flush  input  1  squashes the ID-stage branch this cycle.
- br_valid_in  input  1  ID-stage branch requesting evaluation.
- br_ccc  input  3  branch condition code.
- flags_out  output  3  {Z,V,N} architectural flags, registered.
- br_resolved  output  1  registered; pulses 1 cycle after an accepted evaluation.
- br_taken  output  1  registered; result of that evaluation.
- hazard_stall  output  1  combinational; request a 1-cycle ID stall (FWD_EN=0 only).
- br_total  output  CNT_W  accepted-branch count, saturating.
- br_taken_cnt  output  CNT_W  taken-branch count, saturating.

Behaviour:
- Reset (rst_n low, asynchronous):
  - flags_out=3'b000, br_resolved=0, br_taken=0, both counters=0.
  - Reset mid-evaluation discards the pending result.
- Flag write class of ex_opcode:
  - 0x0, 0x1 (ADD/SUB) write Z, V and N.
  - 0x2, 0x4, 0x5, 0x6 (XOR/SLL/SRA/ROR) write Z only.
  - All other opcodes write nothing.
- Flag update: on posedge when ex_valid && !stall, each written flag takes its *_set value; unwritten flags hold. flush does not block the update, because the EX instruction is older than the squashed branch.
- next_flags = the value the flag register will hold after this edge. It equals flags_out when there is no update.
- Condition codes (F = evaluated flags):
  - 000 NE: !Z.
  - 001 EQ: Z.
  - 010 GT: !Z && !N.
  - 011 LT: N.
  - 100 GE: Z || (!Z && !N).
  - 101 LE: N || Z.
  - 110 OV: V.
  - 111 unconditional: 1.
- Flags read per code: NE/EQ read Z; LT reads N; GT/GE/LE read Z and N; OV reads V; 111 reads none.
- Hazard (FWD_EN=0):
  - hazard_stall = br_valid_in && ex_valid && !flush && (EX writes a flag this ccc reads).
  - While hazard_stall is high, the branch is not accepted.
  - With FWD_EN=1, hazard_stall is tied to 0.
- Acceptance:
  - accept = br_valid_in && !flush && !stall && !hazard_stall.
  - F = next_flags when FWD_EN=1; F = flags_out when FWD_EN=0.
- Result timing:
  - Next edge after accept: br_resolved=1 and br_taken=eval(ccc,F).
  - Next edge without accept and without stall: br_resolved=0; br_taken holds its last value.
  - stall holds br_resolved and br_taken unchanged.
- Counters:
  - On accept, br_total increments; br_taken_cnt increments when the result is taken.
  - Both saturate at all-ones and never wrap.
- Simultaneous flush + br_valid_in: the branch is ignored, the flag update still occurs, and no counter changes.

Test Plan:
- Reset with rst_n=0 mid-sequence: flags_out=000, br_resolved=0, counters=0 immediately, independent of clk.
- ADD with Z_set=0, V_set=1, N_set=1, then XOR with Z_set=1:
  - After ADD: flags_out=3'b011.
  - After XOR: flags_out=3'b111 (V and N held).
  - A following opcode 0x3 with Z_set=0 leaves flags_out unchanged.
- FWD_EN=1, SUB writing Z=1 in the same cycle as an EQ (001) branch: next cycle br_resolved=1, br_taken=1, br_total=1, br_taken_cnt=1.
- FWD_EN=0, same stimulus:
  - hazard_stall=1 for 1 cycle.
  - The branch is accepted the following cycle: br_taken=1.
  - A ccc=111 branch beside an ADD gives hazard_stall=0.
- flush with br_valid_in=1 and SUB in EX: flags update, br_resolved=0 next cycle, counters unchanged.
- stall held 3 cycles during an ADD plus GT branch: flags_out, outputs and counters frozen; the update and evaluation happen on the first unstalled edge.
- Saturation with CNT_W=4: 17 taken unconditional branches leave br_total=4'hF and br_taken_cnt=4'hF.

Source files
------------

// File: rtl/flag_branch_unit.sv
// flag_branch_unit: latches the ALU Z/V/N flags into the architectural flag
// register, masked by opcode class. Evaluates 3-bit branch condition codes
// against those flags and returns a registered result to fetch. Resolves the
// EX-write/ID-read flag hazard either by bypass (FWD_EN=1) or by requesting an
// ID stall (FWD_EN=0). Also keeps saturating branch statistics counters.
module flag_branch_unit #(
  parameter bit FWD_EN = 1'b1,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ex_valid,
  input  logic [3:0]       ex_opcode,
  input  logic             Z_set,
  input  logic             V_set,
  input  logic             N_set,
  input  logic             stall,
  input  logic             flush,
  input  logic             br_valid_in,
  input  logic [2:0]       br_ccc,
  output logic [2:0]       flags_out,
  output logic             br_resolved,
  output logic             br_taken,
  output logic             hazard_stall,
  output logic [CNT_W-1:0] br_total,
  output logic [CNT_W-1:0] br_taken_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  // Flag bit order everywhere is {Z,V,N}.
  logic [2:0]       flags_q, flags_d;
  logic             resolved_q, resolved_d;
  logic             taken_q, taken_d;
  logic [CNT_W-1:0] total_q, total_d;
  logic [CNT_W-1:0] tcnt_q, tcnt_d;

  logic [2:0] wr_mask, rd_mask, next_flags, eval_flags;
  logic       cond_taken, accept;

  // Flags written by the EX opcode: arithmetic writes all, logic/shift writes Z.
  always_comb begin
    wr_mask = 3'b000;
    case (ex_opcode)
      4'h0, 4'h1:             wr_mask = 3'b111;
      4'h2, 4'h4, 4'h5, 4'h6: wr_mask = 3'b100;
      default:                wr_mask = 3'b000;
    endcase
  end

  // Flags a condition code depends on; used only for hazard detection.
  always_comb begin
    rd_mask = 3'b000;
    case (br_ccc)
      3'b000, 3'b001:         rd_mask = 3'b100;
      3'b011:                 rd_mask = 3'b001;
      3'b010, 3'b100, 3'b101: rd_mask = 3'b101;
      3'b110:                 rd_mask = 3'b010;
      default:                rd_mask = 3'b000;
    endcase
  end

  // Flag value after this edge; flush does not gate it since EX is older.
  always_comb begin
    next_flags = flags_q;
    if (ex_valid && !stall)
      next_flags = (flags_q & ~wr_mask) | ({Z_set, V_set, N_set} & wr_mask);
  end

  // Hazard request and branch acceptance; bypass removes the hazard entirely.
  always_comb begin
    hazard_stall = 1'b0;
    if (!FWD_EN)
      hazard_stall = br_valid_in && ex_valid && !flush && |(wr_mask & rd_mask);
    accept     = br_valid_in && !flush && !stall && !hazard_stall;
    eval_flags = FWD_EN ? next_flags : flags_q;
  end

  // Condition evaluation against the selected flags.
  always_comb begin
    cond_taken = 1'b0;
    case (br_ccc)
      3'b000: cond_taken = !eval_flags[2];
      3'b001: cond_taken = eval_flags[2];
      3'b010: cond_taken = !eval_flags[2] && !eval_flags[0];
      3'b011: cond_taken = eval_flags[0];
      3'b100: cond_taken = eval_flags[2] || (!eval_flags[2] && !eval_flags[0]);
      3'b101: cond_taken = eval_flags[0] || eval_flags[2];
      3'b110: cond_taken = eval_flags[1];
      default: cond_taken = 1'b1;
    endcase
  end

  // Next-state for result and counters; stall freezes everything.
  always_comb begin
    flags_d    = next_flags;
    resolved_d = stall ? resolved_q : accept;
    taken_d    = accept ? cond_taken : taken_q;
    total_d    = total_q;
    tcnt_d     = tcnt_q;
    if (accept && total_q != CNT_MAX) total_d = total_q + CNT_ONE;
    if (accept && cond_taken && tcnt_q != CNT_MAX) tcnt_d = tcnt_q + CNT_ONE;
  end

  // State registers with asynchronous reset discarding any pending result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_q    <= 3'b000;
      resolved_q <= 1'b0;
      taken_q    <= 1'b0;
      total_q    <= '0;
      tcnt_q     <= '0;
    end else begin
      flags_q    <= flags_d;
      resolved_q <= resolved_d;
      taken_q    <= taken_d;
      total_q    <= total_d;
      tcnt_q     <= tcnt_d;
    end
  end

  assign flags_out    = flags_q;
  assign br_resolved  = resolved_q;
  assign br_taken     = taken_q;
  assign br_total     = total_q;
  assign br_taken_cnt = tcnt_q;

endmodule

// File: tb/tb_flag_branch_unit.sv
// Bench for flag_branch_unit: three instances share one stimulus stream
// (bypass/16-bit, stall-on-hazard/16-bit, bypass/4-bit counters).
module tb_flag_branch_unit;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ex_valid = 1'b0, Z_set = 1'b0, V_set = 1'b0, N_set = 1'b0;
  logic [3:0] ex_opcode = 4'h0;
  logic       stall = 1'b0, flush = 1'b0, br_valid_in = 1'b0;
  logic [2:0] br_ccc = 3'b000;

  logic [2:0]  o_flags[3];
  logic        o_res[3], o_tak[3], o_hz[3];
  logic [15:0] o_tot[3], o_tc[3];
  logic [3:0]  s_tot, s_tc;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  flag_branch_unit #(.FWD_EN(1'b1), .CNT_W(16)) u_fwd (
    .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_opcode(ex_opcode),
    .Z_set(Z_set), .V_set(V_set), .N_set(N_set), .stall(stall), .flush(flush),
    .br_valid_in(br_valid_in), .br_ccc(br_ccc), .flags_out(o_flags[0]),
    .br_resolved(o_res[0]), .br_taken(o_tak[0]), .hazard_stall(o_hz[0]),
    .br_total(o_tot[0]), .br_taken_cnt(o_tc[0]));

  flag_branch_unit #(.FWD_EN(1'b0), .CNT_W(16)) u_nf (
    .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_opcode(ex_opcode),
    .Z_set(Z_set), .V_set(V_set), .N_set(N_set), .stall(stall), .flush(flush),
    .br_valid_in(br_valid_in), .br_ccc(br_ccc), .flags_out(o_flags[1]),
    .br_resolved(o_res[1]), .br_taken(o_tak[1]), .hazard_stall(o_hz[1]),
    .br_total(o_tot[1]), .br_taken_cnt(o_tc[1]));

  flag_branch_unit #(.FWD_EN(1'b1), .CNT_W(4)) u_sat (
    .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_opcode(ex_opcode),
    .Z_set(Z_set), .V_set(V_set), .N_set(N_set), .stall(stall), .flush(flush),
    .br_valid_in(br_valid_in), .br_ccc(br_ccc), .flags_out(o_flags[2]),
    .br_resolved(o_res[2]), .br_taken(o_tak[2]), .hazard_stall(o_hz[2]),
    .br_total(s_tot), .br_taken_cnt(s_tc));

  assign o_tot[2] = {12'h000, s_tot};
  assign o_tc[2]  = {12'h000, s_tc};

  // ---------------- reference model (spec rules, per instance) -------------
  logic [2:0]  m_flags[3];
  bit          m_res[3], m_tak[3];
  logic [15:0] m_tot[3], m_tc[3];
  logic [15:0] m_max[3] = '{16'hFFFF, 16'hFFFF, 16'h000F};
  bit          m_fwd[3] = '{1'b1, 1'b0, 1'b1};

  function automatic bit writes(input logic [3:0] op, input int b); // b: 2=Z 1=V 0=N
    if (op == 4'h0 || op == 4'h1) return 1'b1;
    if (b == 2 && (op == 4'h2 || op == 4'h4 || op == 4'h5 || op == 4'h6)) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit reads(input logic [2:0] c, input int b);
    case (b)
      2: return (c != 3'd3 && c != 3'd6 && c != 3'd7);
      1: return (c == 3'd6);
      default: return (c == 3'd2 || c == 3'd3 || c == 3'd4 || c == 3'd5);
    endcase
  endfunction

  function automatic bit cond(input logic [2:0] c, input logic [2:0] f);
    bit z, v, n;
    z = f[2]; v = f[1]; n = f[0];
    case (c)
      3'd0: return !z;
      3'd1: return z;
      3'd2: return !z && !n;
      3'd3: return n;
      3'd4: return z || (!z && !n);
      3'd5: return n || z;
      3'd6: return v;
      default: return 1'b1;
    endcase
  endfunction

  function automatic bit m_hazard(input int i);
    bit conflict = 1'b0;
    for (int b = 0; b < 3; b++)
      if (writes(ex_opcode, b) && reads(br_ccc, b)) conflict = 1'b1;
    return !m_fwd[i] && br_valid_in && ex_valid && !flush && conflict;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 3; i++) begin
      m_flags[i] = 3'b000; m_res[i] = 1'b0; m_tak[i] = 1'b0;
      m_tot[i] = 16'h0; m_tc[i] = 16'h0;
    end
  endtask

  task automatic m_step();
    logic [2:0] nf, setv;
    bit acc, t;
    setv = {Z_set, V_set, N_set};
    for (int i = 0; i < 3; i++) begin
      nf = m_flags[i];
      if (ex_valid && !stall)
        for (int b = 0; b < 3; b++) if (writes(ex_opcode, b)) nf[b] = setv[b];
      acc = br_valid_in && !flush && !stall && !m_hazard(i);
      t = cond(br_ccc, m_fwd[i] ? nf : m_flags[i]);
      if (!stall) m_res[i] = acc;
      if (acc) begin
        m_tak[i] = t;
        if (m_tot[i] < m_max[i]) m_tot[i] = m_tot[i] + 16'h1;
        if (t && m_tc[i] < m_max[i]) m_tc[i] = m_tc[i] + 16'h1;
      end
      m_flags[i] = nf;
    end
  endtask

  // ---------------- stimulus helpers ---------------------------------------
  task automatic set_in(input bit ev, input logic [3:0] op, input bit z, input bit v,
                        input bit n, input bit st, input bit fl, input bit bv,
                        input logic [2:0] c);
    ex_valid = ev; ex_opcode = op; Z_set = z; V_set = v; N_set = n;
    stall = st; flush = fl; br_valid_in = bv; br_ccc = c;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    set_in(0, 4'h0, 0, 0, 0, 0, 0, 0, 3'd0);
    rst_n = 1'b0; #2; rst_n = 1'b1;
  endtask

  // ---------------- scenario tasks -----------------------------------------
  task automatic test_reset();
    do_reset();
    set_in(1, 4'h0, 1, 1, 1, 0, 0, 1, 3'd7);
    tick();
    checks++; if (o_flags[0] !== 3'b111 || o_res[0] !== 1'b1 || o_tot[0] !== 16'd1) begin
      failures++; $display("FAIL pre_reset flags=%b res=%b tot=%0d exp 111/1/1", o_flags[0], o_res[0], o_tot[0]); end
    // Branch accepted but reset hits before the resolving edge.
    #2; rst_n = 1'b0; #1;
    checks++; if (o_flags[0] !== 3'b000 || o_res[0] !== 1'b0 || o_tot[0] !== 16'd0 || o_tc[0] !== 16'd0 || o_tak[0] !== 1'b0) begin
      failures++; $display("FAIL async_reset flags=%b res=%b tak=%b tot=%0d tc=%0d exp all 0", o_flags[0], o_res[0], o_tak[0], o_tot[0], o_tc[0]); end
    set_in(0, 4'h0, 0, 0, 0, 0, 0, 0, 3'd0);
    rst_n = 1'b1;
    tick();
    checks++; if (o_res[0] !== 1'b0 || o_tot[0] !== 16'd0) begin
      failures++; $display("FAIL reset_discard res=%b tot=%0d exp 0/0", o_res[0], o_tot[0]); end
  endtask

  task automatic test_flag_write();
    do_reset();
    set_in(1, 4'h0, 0, 1, 1, 0, 0, 0, 3'd0); tick();
    checks++; if (o_flags[0] !== 3'b011) begin
      failures++; $display("FAIL add_flags got=%b exp=011", o_flags[0]); end
    set_in(1, 4'h2, 1, 0, 0, 0, 0, 0, 3'd0); tick();
    checks++; if (o_flags[0] !== 3'b111) begin
      failures++; $display("FAIL xor_flags got=%b exp=111", o_flags[0]); end
    set_in(1, 4'h3, 0, 0, 0, 0, 0, 0, 3'd0); tick();
    checks++; if (o_flags[0] !== 3'b111) begin
      failures++; $display("FAIL op3_noflags got=%b exp=111", o_flags[0]); end
    set_in(0, 4'h1, 0, 0, 0, 0, 0, 0, 3'd0); tick();
    checks++; if (o_flags[0] !== 3'b111) begin
      failures++; $display("FAIL invalid_noflags got=%b exp=111", o_flags[0]); end
  endtask

  task automatic test_forward_hazard();
    do_reset();
    set_in(1, 4'h1, 1, 0, 0, 0, 0, 1, 3'd1); #1;
    checks++; if (o_hz[0] !== 1'b0 || o_hz[1] !== 1'b1) begin
      failures++; $display("FAIL hazard_eq fwd=%b nf=%b exp 0/1", o_hz[0], o_hz[1]); end
    tick();
    checks++; if (o_res[0] !== 1'b1 || o_tak[0] !== 1'b1 || o_tot[0] !== 16'd1 || o_tc[0] !== 16'd1) begin
      failures++; $display("FAIL fwd_eq res=%b tak=%b tot=%0d tc=%0d exp 1/1/1/1", o_res[0], o_tak[0], o_tot[0], o_tc[0]); end
    checks++; if (o_res[1] !== 1'b0 || o_tot[1] !== 16'd0) begin
      failures++; $display("FAIL nf_stalled res=%b tot=%0d exp 0/0", o_res[1], o_tot[1]); end
    set_in(0, 4'h0, 0, 0, 0, 0, 0, 1, 3'd1); #1;
    checks++; if (o_hz[1] !== 1'b0) begin
      failures++; $display("FAIL nf_hazard_clear got=%b exp=0", o_hz[1]); end
    tick();
    checks++; if (o_res[1] !== 1'b1 || o_tak[1] !== 1'b1 || o_tot[1] !== 16'd1) begin
      failures++; $display("FAIL nf_eq res=%b tak=%b tot=%0d exp 1/1/1", o_res[1], o_tak[1], o_tot[1]); end
    set_in(1, 4'h0, 0, 0, 0, 0, 0, 1, 3'd7); #1;
    checks++; if (o_hz[1] !== 1'b0) begin
      failures++; $display("FAIL uncond_no_hazard got=%b exp=0", o_hz[1]); end
    set_in(1, 4'h0, 0, 1, 0, 0, 0, 1, 3'd6); #1;
    checks++; if (o_hz[1] !== 1'b1) begin
      failures++; $display("FAIL ov_hazard got=%b exp=1", o_hz[1]); end
    tick();
  endtask

  task automatic test_flush();
    do_reset();
    set_in(1, 4'h1, 1, 1, 0, 0, 1, 1, 3'd1); #1;
    checks++; if (o_hz[1] !== 1'b0) begin
      failures++; $display("FAIL flush_hazard got=%b exp=0", o_hz[1]); end
    tick();
    checks++; if (o_flags[0] !== 3'b110 || o_flags[1] !== 3'b110 || o_res[0] !== 1'b0 || o_tot[0] !== 16'd0 || o_tc[0] !== 16'd0) begin
      failures++; $display("FAIL flush flags=%b/%b res=%b tot=%0d tc=%0d exp 110/110/0/0/0", o_flags[0], o_flags[1], o_res[0], o_tot[0], o_tc[0]); end
  endtask

  task automatic test_stall();
    do_reset();
    set_in(1, 4'h0, 1, 0, 1, 0, 0, 1, 3'd5); tick();   // flags 101, LE taken
    set_in(1, 4'h0, 0, 0, 0, 1, 0, 1, 3'd2);
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++; if (o_flags[0] !== 3'b101 || o_res[0] !== 1'b1 || o_tak[0] !== 1'b1 || o_tot[0] !== 16'd1) begin
        failures++; $display("FAIL stall_frozen c%0d flags=%b res=%b tak=%b tot=%0d exp 101/1/1/1", k, o_flags[0], o_res[0], o_tak[0], o_tot[0]); end
    end
    stall = 1'b0; tick();
    checks++; if (o_flags[0] !== 3'b000 || o_res[0] !== 1'b1 || o_tak[0] !== 1'b1 || o_tot[0] !== 16'd2 || o_tc[0] !== 16'd2) begin
      failures++; $display("FAIL stall_release flags=%b res=%b tak=%b tot=%0d tc=%0d exp 000/1/1/2/2", o_flags[0], o_res[0], o_tak[0], o_tot[0], o_tc[0]); end
    set_in(0, 4'h0, 0, 0, 0, 0, 0, 1, 3'd1); tick();  // EQ not taken
    set_in(0, 4'h0, 0, 0, 0, 0, 0, 0, 3'd0); tick();
    checks++; if (o_res[0] !== 1'b0 || o_tak[0] !== 1'b0 || o_tot[0] !== 16'd3 || o_tc[0] !== 16'd2) begin
      failures++; $display("FAIL idle_hold res=%b tak=%b tot=%0d tc=%0d exp 0/0/3/2", o_res[0], o_tak[0], o_tot[0], o_tc[0]); end
  endtask

  task automatic test_saturation();
    do_reset();
    set_in(0, 4'h0, 0, 0, 0, 0, 0, 1, 3'd7);
    for (int k = 0; k < 17; k++) tick();
    checks++; if (s_tot !== 4'hF || s_tc !== 4'hF) begin
      failures++; $display("FAIL saturate tot=%h tc=%h exp F/F", s_tot, s_tc); end
    checks++; if (o_tot[0] !== 16'd17 || o_tc[0] !== 16'd17) begin
      failures++; $display("FAIL wide_count tot=%0d tc=%0d exp 17/17", o_tot[0], o_tc[0]); end
    set_in(0, 4'h0, 0, 0, 0, 0, 0, 0, 3'd0); tick();
  endtask

  task automatic test_random();
    do_reset();
    m_reset();
    for (int k = 0; k < 400; k++) begin
      set_in($urandom_range(0, 1), 4'($urandom_range(0, 15)), $urandom_range(0, 1),
             $urandom_range(0, 1), $urandom_range(0, 1), ($urandom_range(0, 5) == 0),
             ($urandom_range(0, 5) == 0), ($urandom_range(0, 3) != 0),
             3'($urandom_range(0, 7)));
      #1;
      for (int i = 0; i < 3; i++) begin
        checks++; if (o_hz[i] !== m_hazard(i)) begin
          failures++; $display("FAIL rand_hazard u%0d cyc%0d got=%b exp=%b", i, k, o_hz[i], m_hazard(i)); end
      end
      m_step();
      tick();
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (o_flags[i] !== m_flags[i] || o_res[i] !== m_res[i] || o_tak[i] !== m_tak[i] ||
            o_tot[i] !== m_tot[i] || o_tc[i] !== m_tc[i]) begin
          failures++;
          $display("FAIL rand_state u%0d cyc%0d got f=%b r=%b t=%b tot=%0d tc=%0d exp f=%b r=%b t=%b tot=%0d tc=%0d",
                   i, k, o_flags[i], o_res[i], o_tak[i], o_tot[i], o_tc[i],
                   m_flags[i], m_res[i], m_tak[i], m_tot[i], m_tc[i]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_flag_write();
    test_forward_hazard();
    test_flush();
    test_stall();
    test_saturation();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
